// File: rtl/sprite_blitter_if.sv
// Bus between the sprite blitter, its sprite RAM and the vga_adapter write port.
// The blitter takes the slave side; the game controller / bench takes the master side.
interface sprite_blitter_if #(
  parameter int XW  = 8,
  parameter int YW  = 7,
  parameter int SXW = 4,
  parameter int SYW = 3,
  parameter int CW  = 3
);
  logic           start;
  logic [XW-1:0]  base_x;
  logic [YW-1:0]  base_y;
  logic [SXW-1:0] spr_x;
  logic [SYW-1:0] spr_y;
  logic [CW-1:0]  spr_color;
  logic [XW-1:0]  vga_x;
  logic [YW-1:0]  vga_y;
  logic [CW-1:0]  vga_color;
  logic           vga_plot;
  logic           busy;
  logic           done;

  modport slave (
    input  start, base_x, base_y, spr_color,
    output spr_x, spr_y, vga_x, vga_y, vga_color, vga_plot, busy, done
  );

  modport master (
    output start, base_x, base_y, spr_color,
    input  spr_x, spr_y, vga_x, vga_y, vga_color, vga_plot, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Raster-sweeps a sprite RAM and writes each pixel to the frame buffer at a latched
// screen origin, dropping transparent pixels and pixels that fall off the screen.
module sprite_blitter #(
  parameter int             SCREEN_W          = 160,
  parameter int             SCREEN_H          = 120,
  parameter int             XW                = 8,
  parameter int             YW                = 7,
  parameter int             SPR_W             = 10,
  parameter int             SPR_H             = 6,
  parameter int             SXW               = 4,
  parameter int             SYW               = 3,
  parameter int             CW                = 3,
  parameter int             TRANSPARENT_EN    = 1,
  parameter logic [CW-1:0]  TRANSPARENT_COLOR = 3'b000
) (
  input logic              clk,
  input logic              reset,
  sprite_blitter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]     state;
  logic           drain_cnt;
  logic           done_q;
  logic [XW-1:0]  base_x_q;
  logic [YW-1:0]  base_y_q;
  logic [SXW-1:0] spr_x_q;
  logic [SYW-1:0] spr_y_q;

  logic           s1_valid;
  logic [SXW-1:0] s1_x;
  logic [SYW-1:0] s1_y;

  logic [XW-1:0]  vga_x_q;
  logic [YW-1:0]  vga_y_q;
  logic [CW-1:0]  vga_color_q;
  logic           vga_plot_q;

  logic [XW:0]    x_sum;
  logic [YW:0]    y_sum;
  logic           transparent;
  logic           clipped;
  logic           plot_next;
  logic           last_col;
  logic           last_row;

  // One carry bit on each sum so sprites hanging off the right/bottom edge clip
  // instead of wrapping back onto the left/top of the screen.
  always_comb begin
    x_sum       = {1'b0, base_x_q} + {{(XW + 1 - SXW){1'b0}}, s1_x};
    y_sum       = {1'b0, base_y_q} + {{(YW + 1 - SYW){1'b0}}, s1_y};
    transparent = (TRANSPARENT_EN != 0) && (bus.spr_color == TRANSPARENT_COLOR);
    clipped     = (x_sum >= (XW + 1)'(SCREEN_W)) || (y_sum >= (YW + 1)'(SCREEN_H));
    plot_next   = s1_valid && !transparent && !clipped;
    last_col    = (spr_x_q == SXW'(SPR_W - 1));
    last_row    = (spr_y_q == SYW'(SPR_H - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      done_q    <= 1'b0;
      base_x_q  <= '0;
      base_y_q  <= '0;
      spr_x_q   <= '0;
      spr_y_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          spr_x_q <= '0;
          spr_y_q <= '0;
          if (bus.start) begin
            base_x_q <= bus.base_x;
            base_y_q <= bus.base_y;
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          if (last_col) begin
            spr_x_q <= '0;
            if (last_row) begin
              spr_y_q   <= '0;
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end else begin
              spr_y_q <= spr_y_q + SYW'(1);
            end
          end else begin
            spr_x_q <= spr_x_q + SXW'(1);
          end
        end
        DRAIN: begin
          // Two flush cycles cover the RAM read and the output register.
          if (drain_cnt) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 lines the address up with the RAM's registered data; stage 2 drives
  // the frame buffer, and coordinates/colour only move when a pixel is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      vga_plot_q  <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
    end else begin
      s1_valid   <= (state == SWEEP);
      s1_x       <= spr_x_q;
      s1_y       <= spr_y_q;
      vga_plot_q <= plot_next;
      if (plot_next) begin
        vga_x_q     <= x_sum[XW-1:0];
        vga_y_q     <= y_sum[YW-1:0];
        vga_color_q <= bus.spr_color;
      end
    end
  end

  assign bus.spr_x     = spr_x_q;
  assign bus.spr_y     = spr_y_q;
  assign bus.vga_x     = vga_x_q;
  assign bus.vga_y     = vga_y_q;
  assign bus.vga_color = vga_color_q;
  assign bus.vga_plot  = vga_plot_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Drives two blitters (transparency on/off) from one sprite RAM image and compares
// every cycle against a pixel-list model derived from the draw rules.
module tb_sprite_blitter;
  localparam int W = 10;
  localparam int H = 6;
  localparam int N = W * H;

  logic clk;
  logic reset;
  logic in_start;
  logic [7:0] in_bx;
  logic [6:0] in_by;
  logic [2:0] ram [N];

  int cyc;
  int checks;
  int errors;
  int cnt_t;
  int cnt_o;

  bit m_active;
  int m_t0;
  int m_bx;
  int m_by;
  int m_lx [2];
  int m_ly [2];
  int m_lc [2];

  sprite_blitter_if #(.XW(8), .YW(7), .SXW(4), .SYW(3), .CW(3)) bus_t ();
  sprite_blitter_if #(.XW(8), .YW(7), .SXW(4), .SYW(3), .CW(3)) bus_o ();

  sprite_blitter #(.TRANSPARENT_EN(1)) dut_t (.clk(clk), .reset(reset), .bus(bus_t.slave));
  sprite_blitter #(.TRANSPARENT_EN(0)) dut_o (.clk(clk), .reset(reset), .bus(bus_o.slave));

  assign bus_t.start  = in_start;
  assign bus_t.base_x = in_bx;
  assign bus_t.base_y = in_by;
  assign bus_o.start  = in_start;
  assign bus_o.base_x = in_bx;
  assign bus_o.base_y = in_by;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite RAMs with one cycle of registered read latency.
  always @(posedge clk) begin
    bus_t.spr_color <= ram[int'(bus_t.spr_y) * W + int'(bus_t.spr_x)];
    bus_o.spr_color <= ram[int'(bus_o.spr_y) * W + int'(bus_o.spr_x)];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit visible(int k, bit te);
    int xs;
    int ys;
    xs = m_bx + k % W;
    ys = m_by + k / W;
    return (xs < 160) && (ys < 120) && !(te && ram[k] == 3'b000);
  endfunction

  task automatic checkCycle();
    for (int d = 0; d < 2; d++) begin
      bit te;
      int rel;
      int k;
      logic e_busy, e_done, e_plot;
      int e_sx, e_sy;
      logic o_busy, o_done, o_plot;
      logic [31:0] o_sx, o_sy, o_x, o_y, o_c;
      string p;
      te = (d == 0);
      p = te ? "t" : "o";
      rel = m_active ? cyc - m_t0 : -1000;
      e_busy = (rel >= 1) && (rel <= N + 2);
      e_done = (rel == N + 3);
      e_sx = 0;
      e_sy = 0;
      if (rel >= 1 && rel <= N) begin
        e_sx = (rel - 1) % W;
        e_sy = (rel - 1) / W;
      end
      k = rel - 3;
      e_plot = (k >= 0) && (k < N) && visible(k, te);
      if (e_plot) begin
        m_lx[d] = m_bx + k % W;
        m_ly[d] = m_by + k / W;
        m_lc[d] = int'(ram[k]);
      end
      if (te) begin
        o_busy = bus_t.busy; o_done = bus_t.done; o_plot = bus_t.vga_plot;
        o_sx = 32'(bus_t.spr_x); o_sy = 32'(bus_t.spr_y);
        o_x = 32'(bus_t.vga_x); o_y = 32'(bus_t.vga_y); o_c = 32'(bus_t.vga_color);
        if (o_plot === 1'b1) cnt_t++;
      end else begin
        o_busy = bus_o.busy; o_done = bus_o.done; o_plot = bus_o.vga_plot;
        o_sx = 32'(bus_o.spr_x); o_sy = 32'(bus_o.spr_y);
        o_x = 32'(bus_o.vga_x); o_y = 32'(bus_o.vga_y); o_c = 32'(bus_o.vga_color);
        if (o_plot === 1'b1) cnt_o++;
      end
      checkOutput({p, ".busy"}, 32'(o_busy), 32'(e_busy));
      checkOutput({p, ".done"}, 32'(o_done), 32'(e_done));
      checkOutput({p, ".plot"}, 32'(o_plot), 32'(e_plot));
      checkOutput({p, ".spr_x"}, o_sx, 32'(e_sx));
      checkOutput({p, ".spr_y"}, o_sy, 32'(e_sy));
      checkOutput({p, ".vga_x"}, o_x, 32'(m_lx[d]));
      checkOutput({p, ".vga_y"}, o_y, 32'(m_ly[d]));
      checkOutput({p, ".vga_color"}, o_c, 32'(m_lc[d]));
    end
  endtask

  // Inputs are held for one cycle; the model reacts to them exactly as the draw
  // rules say, then the following cycle is compared.
  task automatic applyStimulus(input logic st, input logic [7:0] bx, input logic [6:0] by,
                               input logic rs);
    in_start = st;
    in_bx    = bx;
    in_by    = by;
    reset    = rs;
    if (rs) begin
      m_active = 0;
      for (int d = 0; d < 2; d++) begin
        m_lx[d] = 0; m_ly[d] = 0; m_lc[d] = 0;
      end
    end else if (st && (!m_active || (cyc - m_t0) >= N + 3)) begin
      m_active = 1;
      m_t0 = cyc;
      m_bx = int'(bx);
      m_by = int'(by);
    end
    @(posedge clk);
    #1;
    cyc++;
    checkCycle();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'($urandom), 7'($urandom), 1'b0);
  endtask

  task automatic fillRam(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0: ram[y * W + x] = 3'b101;
          1: ram[y * W + x] = ((x + y) % 2 == 0) ? 3'b000 : 3'b011;
          2: ram[y * W + x] = 3'b111;
          default: ram[y * W + x] = 3'($urandom_range(0, 7));
        endcase
  endtask

  task automatic runDraw(input logic [7:0] bx, input logic [6:0] by, input int exp_t,
                         input int exp_o, input string tag);
    cnt_t = 0;
    cnt_o = 0;
    applyStimulus(1'b1, bx, by, 1'b0);
    repeat (N + 3) idle();
    checkOutput({tag, ".plots_t"}, 32'(cnt_t), 32'(exp_t));
    checkOutput({tag, ".plots_o"}, 32'(cnt_o), 32'(exp_o));
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; cnt_t = 0; cnt_o = 0;
    m_active = 0; m_t0 = 0; m_bx = 0; m_by = 0;
    for (int d = 0; d < 2; d++) begin
      m_lx[d] = 0; m_ly[d] = 0; m_lc[d] = 0;
    end
    in_start = 0; in_bx = 0; in_by = 0; reset = 1;
    fillRam(0);
    repeat (3) applyStimulus(1'b0, 8'd0, 7'd0, 1'b1);
    repeat (2) idle();

    fillRam(0);
    runDraw(8'd0, 7'd0, 60, 60, "base00");
    fillRam(1);
    runDraw(8'd20, 7'd30, 30, 60, "checker");
    fillRam(2);
    runDraw(8'd155, 7'd117, 15, 15, "clip");
    runDraw(8'd255, 7'd0, 0, 0, "wrap");

    // Restart attempt mid-draw is ignored; restart in the done cycle is taken.
    fillRam(0);
    cnt_t = 0; cnt_o = 0;
    applyStimulus(1'b1, 8'd40, 7'd20, 1'b0);
    for (int r = 1; r <= 62; r++)
      if (r == 10) applyStimulus(1'b1, 8'd50, 7'd50, 1'b0);
      else idle();
    checkOutput("hs.plots_t", 32'(cnt_t), 32'd60);
    cnt_t = 0; cnt_o = 0;
    applyStimulus(1'b1, 8'd60, 7'd70, 1'b0);
    checkOutput("hs.busy_next", 32'(bus_t.busy), 32'd1);
    repeat (N + 3) idle();
    checkOutput("hs2.plots_t", 32'(cnt_t), 32'd60);

    // Reset in cycle 20 of a draw: pixels 0..17 reach the screen, nothing after.
    cnt_t = 0; cnt_o = 0;
    applyStimulus(1'b1, 8'd0, 7'd0, 1'b0);
    repeat (19) idle();
    applyStimulus(1'b0, 8'd0, 7'd0, 1'b1);
    repeat (50) idle();
    checkOutput("abort.plots_t", 32'(cnt_t), 32'd18);
    runDraw(8'd0, 7'd0, 60, 60, "after_abort");

    for (int it = 0; it < 25; it++) begin
      logic [7:0] bx;
      logic [6:0] by;
      int abort_at;
      bit aborted;
      fillRam(3);
      bx = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(148, 165));
      by = ($urandom_range(0, 1) == 0) ? 7'($urandom) : 7'($urandom_range(112, 124));
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N + 2)) : -1;
      aborted = 0;
      repeat ($urandom_range(0, 3)) idle();
      applyStimulus(1'b1, bx, by, 1'b0);
      for (int r = 1; r <= N + 3; r++) begin
        if (r == abort_at) begin
          applyStimulus(1'b0, 8'($urandom), 7'($urandom), 1'b1);
          aborted = 1;
        end else if (!aborted && r <= N + 2 && $urandom_range(0, 9) == 0) begin
          applyStimulus(1'b1, 8'($urandom), 7'($urandom), 1'b0);
        end else begin
          idle();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
